// File: rtl/slow_cfg_pkg.sv
// Shared layout of the slow-mode settings word, common to the settings latch
// (write side, address-encoded) and the readback responder (read side).
package slow_cfg_pkg;

  localparam int DATA_W         = 16;
  localparam int VERSION_LSB    = 12;
  localparam int TIMEOUT_MSB    = 11;
  localparam int TIMEOUT_LSB    = 8;
  localparam int IACK_BIT       = 7;
  localparam int VIA_BIT        = 6;
  localparam int IWM_BIT        = 5;
  localparam int SCC_BIT        = 4;
  localparam int SCSI_BIT       = 3;
  localparam int SND_BIT        = 2;
  localparam int CLOCK_GATE_BIT = 1;

  // Field order matches A[11:1] on a settings write, MSB first.
  typedef struct packed {
    logic [3:0] timeout;
    logic       iack;
    logic       via;
    logic       iwm;
    logic       scc;
    logic       scsi;
    logic       snd;
    logic       clockGate;
  } SlowSettings;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    ACK,
    END
  } ReadState;

  function automatic logic [DATA_W-1:0] packReadback(input logic [3:0] version,
                                                      input SlowSettings s);
    logic [DATA_W-1:0] d;
    d                           = '0;
    d[DATA_W-1:VERSION_LSB]     = version;
    d[TIMEOUT_MSB:TIMEOUT_LSB]  = s.timeout;
    d[IACK_BIT]                 = s.iack;
    d[VIA_BIT]                  = s.via;
    d[IWM_BIT]                  = s.iwm;
    d[SCC_BIT]                  = s.scc;
    d[SCSI_BIT]                 = s.scsi;
    d[SND_BIT]                  = s.snd;
    d[CLOCK_GATE_BIT]           = s.clockGate;
    return d;
  endfunction

endpackage

// File: rtl/set_readback.sv
// CPU read responder for the slow-mode settings window: snapshots the settings
// on a qualified read, drives them on D and requests DTACK after ACK_WAIT clocks.
module set_readback
  import slow_cfg_pkg::*;
#(
  parameter logic [3:0] VERSION  = 4'h1,
  parameter int         ACK_WAIT = 2
) (
  input  logic              CLK,
  input  logic              nPOR,
  input  logic              BACT,
  input  logic              SetCSRD,
  input  logic [3:0]        SlowTimeout,
  input  logic [6:0]        SlowFlags,
  output logic [DATA_W-1:0] D,
  output logic              DOE,
  output logic              Ready
);

  localparam logic [2:0] ACK_WAIT_CNT = 3'(ACK_WAIT);

  ReadState          state, nextState;
  logic              rdqR, rdqRR;
  logic              start;
  logic [2:0]        waitCnt, nextWaitCnt;
  SlowSettings       snapshot, nextSnapshot;
  logic [DATA_W-1:0] nextD;
  logic              nextDOE, nextReady;

  // Edge-detect on the registered qualifier so a held select fires only once.
  assign start = rdqR && !rdqRR;

  // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
  always_comb begin
    nextState    = state;
    nextWaitCnt  = waitCnt;
    nextSnapshot = snapshot;
    nextD        = '0;
    nextDOE      = 1'b0;
    nextReady    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          nextSnapshot = SlowSettings'({SlowTimeout, SlowFlags});
          nextWaitCnt  = ACK_WAIT_CNT;
          nextState    = DRIVE;
        end
      end
      DRIVE: begin
        nextDOE = 1'b1;
        nextD   = packReadback(VERSION, snapshot);
        if (!BACT) begin
          nextState = END;
        end else if (waitCnt == 3'd0) begin
          nextState = ACK;
        end else begin
          nextWaitCnt = waitCnt - 3'd1;
        end
      end
      ACK: begin
        nextDOE   = 1'b1;
        nextReady = 1'b1;
        nextD     = packReadback(VERSION, snapshot);
        if (!BACT) nextState = END;
      end
      END: begin
        // One dead cycle so our drivers are off before anyone else drives D.
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: state and output registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state    <= IDLE;
      rdqR     <= 1'b0;
      rdqRR    <= 1'b0;
      waitCnt  <= '0;
      snapshot <= '0;
      D        <= '0;
      DOE      <= 1'b0;
      Ready    <= 1'b0;
    end else begin
      state    <= nextState;
      rdqR     <= BACT && SetCSRD;
      rdqRR    <= rdqR;
      waitCnt  <= nextWaitCnt;
      snapshot <= nextSnapshot;
      D        <= nextD;
      DOE      <= nextDOE;
      Ready    <= nextReady;
    end
  end

endmodule

// File: tb/tb_set_readback.sv
// Bench for set_readback: three instances (ACK_WAIT 2, 4, 0) share one bus and are
// compared every cycle against an edge-timeline model of the read protocol.
module tb_set_readback;

  logic        CLK = 1'b0;
  logic        nPOR;
  logic        BACT;
  logic        SetCSRD;
  logic [3:0]  SlowTimeout;
  logic [6:0]  SlowFlags;

  logic [15:0] d0, d1, d2;
  logic        doe0, doe1, doe2;
  logic        ready0, ready1, ready2;

  logic [15:0] dOut [3];
  logic        doeOut [3];
  logic        readyOut [3];

  assign dOut[0] = d0;     assign dOut[1] = d1;     assign dOut[2] = d2;
  assign doeOut[0] = doe0; assign doeOut[1] = doe1; assign doeOut[2] = doe2;
  assign readyOut[0] = ready0; assign readyOut[1] = ready1; assign readyOut[2] = ready2;

  localparam int WAITS [3] = '{2, 4, 0};

  set_readback #(.VERSION(4'h1), .ACK_WAIT(2)) dut0 (
    .CLK(CLK), .nPOR(nPOR), .BACT(BACT), .SetCSRD(SetCSRD),
    .SlowTimeout(SlowTimeout), .SlowFlags(SlowFlags),
    .D(d0), .DOE(doe0), .Ready(ready0));

  set_readback #(.VERSION(4'h1), .ACK_WAIT(4)) dut1 (
    .CLK(CLK), .nPOR(nPOR), .BACT(BACT), .SetCSRD(SetCSRD),
    .SlowTimeout(SlowTimeout), .SlowFlags(SlowFlags),
    .D(d1), .DOE(doe1), .Ready(ready1));

  set_readback #(.VERSION(4'h1), .ACK_WAIT(0)) dut2 (
    .CLK(CLK), .nPOR(nPOR), .BACT(BACT), .SetCSRD(SetCSRD),
    .SlowTimeout(SlowTimeout), .SlowFlags(SlowFlags),
    .D(d2), .DOE(doe2), .Ready(ready2));

  always #5 CLK = ~CLK;

  int          testCount = 0;
  int          failCount = 0;

  // Model: each read is an accept edge plus an end edge (first BACT-low sample).
  int          edgeN = 0;
  bit          q1, q2;
  bit          act [3];
  int          acc [3];
  int          endE [3];
  logic [15:0] cap [3];
  logic        expDoe [3];
  logic        expReady [3];
  logic [15:0] expD [3];
  int          readyRise [3];
  logic        readyPrev [3];

  function automatic logic [15:0] refWord(input logic [3:0] t, input logic [6:0] f);
    return {4'h1, t, f, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q1 = 1'b0;
    q2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      act[i]      = 1'b0;
      acc[i]      = 0;
      endE[i]     = -1;
      cap[i]      = 16'h0;
      expDoe[i]   = 1'b0;
      expReady[i] = 1'b0;
      expD[i]     = 16'h0;
    end
  endtask

  task automatic modelStep();
    bit start;
    start = q1 && !q2;
    edgeN++;
    for (int i = 0; i < 3; i++) begin
      if (act[i] && endE[i] < 0 && edgeN > acc[i] && !BACT) endE[i] = edgeN;
      if (start && (!act[i] || (endE[i] >= 0 && edgeN >= endE[i] + 2))) begin
        act[i]  = 1'b1;
        acc[i]  = edgeN;
        endE[i] = -1;
        cap[i]  = refWord(SlowTimeout, SlowFlags);
      end
      expDoe[i]   = act[i] && edgeN >= acc[i] + 1 && (endE[i] < 0 || edgeN <= endE[i]);
      expReady[i] = expDoe[i] && edgeN >= acc[i] + 2 + WAITS[i];
      expD[i]     = expDoe[i] ? cap[i] : 16'h0;
    end
    q2 = q1;
    q1 = BACT && SetCSRD;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (nPOR) modelStep();
    else modelReset();
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("doe%0d@%0d", i, edgeN), {15'b0, doeOut[i]}, {15'b0, expDoe[i]});
      check($sformatf("ready%0d@%0d", i, edgeN), {15'b0, readyOut[i]}, {15'b0, expReady[i]});
      check($sformatf("d%0d@%0d", i, edgeN), dOut[i], expD[i]);
      if (readyOut[i] && !readyPrev[i]) readyRise[i]++;
      readyPrev[i] = readyOut[i];
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic clearRises();
    for (int i = 0; i < 3; i++) readyRise[i] = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nPOR = 1'b0; BACT = 1'b0; SetCSRD = 1'b0;
    SlowTimeout = 4'h0; SlowFlags = 7'h0;
    for (int i = 0; i < 3; i++) readyPrev[i] = 1'b0;
    clearRises();
    modelReset();
    cycles(3);
    check("reset_d", d0, 16'h0000);
    check("reset_doe", {15'b0, doe0}, 16'd0);
    nPOR = 1'b1;
    cycles(4);

    // Basic read, snapshot coherency, select dropped after capture
    SlowTimeout = 4'hA; SlowFlags = 7'b1010101;
    BACT = 1'b1; SetCSRD = 1'b1;
    cycles(3);
    check("basic_doe_e2", {15'b0, doe0}, 16'd1);
    check("basic_d_e2", d0, 16'h1AAA);
    check("basic_ready_e2", {15'b0, ready0}, 16'd0);
    SlowTimeout = 4'h3;
    SetCSRD = 1'b0;
    cycles(2);
    check("basic_ready_e4", {15'b0, ready0}, 16'd0);
    tick();
    check("basic_ready_e5", {15'b0, ready0}, 16'd1);
    check("coherent_d_e5", d0, 16'h1AAA);
    cycles(3);
    check("basic_ready_held", {15'b0, ready0}, 16'd1);
    check("coherent_d_held", d0, 16'h1AAA);
    BACT = 1'b0;
    tick();
    tick();
    check("turnaround_doe", {15'b0, doe0}, 16'd0);
    check("turnaround_ready", {15'b0, ready0}, 16'd0);
    cycles(3);

    // Next read picks up the new timeout
    BACT = 1'b1; SetCSRD = 1'b1;
    cycles(3);
    check("second_read_d", d0, 16'h13AA);
    cycles(4);
    BACT = 1'b0; SetCSRD = 1'b0;
    cycles(4);

    // Early abort one cycle after DOE
    clearRises();
    BACT = 1'b1; SetCSRD = 1'b1;
    cycles(3);
    check("abort_doe_on", {15'b0, doe1}, 16'd1);
    tick();
    BACT = 1'b0; SetCSRD = 1'b0;
    tick();
    tick();
    check("abort_doe_off", {15'b0, doe1}, 16'd0);
    cycles(6);
    check("abort_rises_w4", readyRise[1][15:0], 16'd0);
    check("abort_rises_w2", readyRise[0][15:0], 16'd0);
    check("abort_rises_w0", readyRise[2][15:0], 16'd1);

    // ACK_WAIT=0 with reset-default settings
    SlowTimeout = 4'h0; SlowFlags = 7'b1111110;
    BACT = 1'b1; SetCSRD = 1'b1;
    cycles(3);
    check("w0_doe", {15'b0, doe2}, 16'd1);
    check("w0_ready_early", {15'b0, ready2}, 16'd0);
    check("w0_d", d2, 16'h10FC);
    tick();
    check("w0_ready", {15'b0, ready2}, 16'd1);
    cycles(2);
    BACT = 1'b0; SetCSRD = 1'b0;
    cycles(4);

    // Write cycle, then two back-to-back reads with the select held throughout
    clearRises();
    BACT = 1'b1; SetCSRD = 1'b0;
    cycles(5);
    check("write_doe", {15'b0, doe0}, 16'd0);
    check("write_ready", {15'b0, ready0}, 16'd0);
    BACT = 1'b0;
    tick();
    BACT = 1'b1; SetCSRD = 1'b1;
    cycles(8);
    BACT = 1'b0;
    tick();
    BACT = 1'b1;
    cycles(8);
    BACT = 1'b0;
    cycles(4);
    SetCSRD = 1'b0;
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_rises%0d", i), readyRise[i][15:0], 16'd2);

    // Randomized bus activity
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) BACT = ~BACT;
      if ($urandom_range(0, 3) == 0) SetCSRD = ~SetCSRD;
      if ($urandom_range(0, 4) == 0) SlowTimeout = 4'($urandom);
      if ($urandom_range(0, 4) == 0) SlowFlags = 7'($urandom);
      tick();
    end
    BACT = 1'b0; SetCSRD = 1'b0;
    cycles(4);

    // Asynchronous reset while acknowledging
    SlowTimeout = 4'h5; SlowFlags = 7'b0110011;
    BACT = 1'b1; SetCSRD = 1'b1;
    cycles(6);
    check("pre_reset_ready", {15'b0, ready0}, 16'd1);
    #2;
    nPOR = 1'b0;
    #1;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_doe%0d", i), {15'b0, doeOut[i]}, 16'd0);
      check($sformatf("async_ready%0d", i), {15'b0, readyOut[i]}, 16'd0);
      check($sformatf("async_d%0d", i), dOut[i], 16'h0000);
    end
    tick();
    BACT = 1'b0; SetCSRD = 1'b0;
    cycles(2);
    nPOR = 1'b1;
    cycles(6);
    check("post_reset_doe", {15'b0, doe0}, 16'd0);
    check("post_reset_ready", {15'b0, ready0}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/set_readback.md
Name: set_readback

Overview:
- Bus responder for the CPU read side of the slow-mode settings window. The existing settings latch takes writes whose address bits carry the settings.
- On a qualified read it snapshots the current settings, drives them onto the data bus in the same bit positions the write encodes, and acknowledges after a programmable wait.
- Sits beside the settings latch. Its outputs are merged into the CPLD data-bus mux and the DTACK logic.

Parameters:
- VERSION, 4'h1, constant returned in D[15:12] so software can identify the CPLD image.
- ACK_WAIT, 2, CLK cycles between data drive and Ready assertion; legal range 0..7.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- nPOR  in  1  asynchronous, active-low reset.
- BACT  in  1  CPU bus cycle active; high from address strobe to end of cycle.
- SetCSRD  in  1  decoded read select for the settings window; valid while BACT is high.
- SlowTimeout  in  4  current timeout setting from the settings latch.
- SlowFlags  in  7  {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd, SlowClockGate}.
- D  out  16  readback data.
- DOE  out  1  data-bus output enable for D.
- Ready  out  1  cycle acknowledge request to the DTACK generator.

Behaviour:
Reset and output register:
- nPOR low, asynchronously: state=IDLE, snapshot=0, wait counter=0, D=16'h0000, DOE=0, Ready=0.
- D, DOE and Ready are registered outputs. No output is a combinational function of the inputs.

Data format:
- D[15:12]=VERSION.
- D[11:8]=SlowTimeout.
- D[7:1]=SlowFlags, with SlowIACK on D[7] through SlowClockGate on D[1].
- D[0]=0.
- This is the same bit layout as the write address A[11:1].

Read qualification:
- rdq = BACT && SetCSRD, registered once, as on the write side.
- Start condition is the rising edge of rdq: rdq_r && !rdq_rr.
- A cycle whose select is held continuously never retriggers.

FSM states:
- IDLE: DOE=0, Ready=0. On start, capture the snapshot from SlowTimeout and SlowFlags, load wait counter=ACK_WAIT, go to DRIVE.
- DRIVE: DOE=1, D=snapshot. If counter==0, go to ACK; else decrement.
- ACK: DOE=1, Ready=1. Hold until BACT is low, then go to END.
- END: DOE=0, Ready=0 for exactly one cycle (bus turnaround), then go to IDLE.

Timing:
- Latency from the BACT/SetCSRD-high sample edge: DOE asserts 2 edges later. Ready asserts 2+ACK_WAIT+1 edges later.
- ACK_WAIT=0: Ready asserts the cycle after DOE.

Boundary conditions:
- Snapshot coherency: D reflects the settings at the capture edge only. A write landing during DRIVE or ACK does not change D.
- Early abort: BACT low in DRIVE goes directly to END. Ready never asserts, and DOE drops the next cycle.
- SetCSRD deasserting while BACT stays high has no effect after capture.
- Back-to-back reads: a start seen in END is ignored. A new cycle needs BACT low then high again, so reads are separated by at least END plus re-qualification.
- Reset mid-operation: DOE and Ready drop immediately (asynchronously). No acknowledge is issued after release until a new start.
- Write cycles (SetCSRD low) never affect state.

Decomposition:
- Shared package slow_cfg_pkg holds:
  - the bit-position constants for timeout [11:8] and each flag bit 7..1;
  - the 11-bit settings struct, shared with the settings latch so write and read layouts cannot diverge;
  - the FSM state enum {IDLE, DRIVE, ACK, END}.
- No sub-module needed; the wait counter is a few lines inline.

Test Plan:
- Reset: nPOR low mid-ACK -> DOE=0, Ready=0, D=0 within the same cycle. After release, with no BACT, outputs stay low.
- Basic read:
  - Inputs: SlowTimeout=4'hA, SlowFlags=7'b1010101, ACK_WAIT=2.
  - BACT and SetCSRD rise at edge 0.
  - Required: DOE=1 at edge 2, D=16'h1AAA, Ready=1 at edge 5, held until BACT falls. DOE=0 the edge after BACT low, for one END cycle.
- Coherency: change SlowTimeout from 4'hA to 4'h3 during DRIVE -> D remains 16'h1AAA through ACK. The next read returns 16'h13AA.
- Early abort: drop BACT one cycle after DOE with ACK_WAIT=4 -> Ready never asserts, DOE low one cycle later, FSM returns to IDLE.
- ACK_WAIT=0 and reset defaults (all flags 1, timeout 0, ClockGate 0): D=16'h10FC, Ready asserts one cycle after DOE.
- Write cycle (BACT=1, SetCSRD=0) then two back-to-back reads:
  - The write produces no DOE and no Ready.
  - Each read produces exactly one Ready pulse train.
  - A select held across END does not retrigger.
